// File: rtl/cache_bus_slave.sv
// cache_bus_slave
// ---------------------------------------------------------------------------
// Cache-side endpoint of the CPU<->cache line bus (A1/D1/C1/DUMP).
// Decodes bus commands, deserialises 8-beat write bursts into one line,
// runs a request/acknowledge handshake with the cache core, and for reads
// serialises the returned line back onto D1 tagged C2_RESPONSE on C1.
//
// Core handshake: core_req rises with core_we/core_addr/core_wdata already
// stable and all four stay stable until core_ack is sampled high on a
// posedge; that edge completes the transfer and drops core_req. core_ack
// is ignored whenever core_req is low. For reads core_rdata must be valid
// in the same cycle as core_ack.
//
// Ports:
//   clk          system clock, all state updates on posedge
//   rst_n        asynchronous active-low reset
//   A1           line address, valid in the command cycle
//   D1           data beats (inout), driven only while responding, else Z
//   C1           command in / response out (inout), driven only while responding
//   DUMP         dump request from master
//   core_req     request to cache core, held until core_ack
//   core_we      1 = line write, 0 = line read
//   core_addr    latched A1
//   core_wdata   assembled write line
//   core_ack     core accept/complete pulse
//   core_rdata   read line, valid with core_ack on reads
//   core_dump    one-cycle dump pulse to the core
//   busy         registered, high whenever the FSM is not IDLE
//   dbg_state_o  current FSM state for observation
// ---------------------------------------------------------------------------
module cache_bus_slave #(
    parameter int unsigned      ADDR_W        = 15,
    parameter int unsigned      DATA_W        = 16,
    parameter int unsigned      CTR_W         = 3,
    parameter int unsigned      BEATS         = 8,
    parameter logic [CTR_W-1:0] C2_NOP        = 3'd0,
    parameter logic [CTR_W-1:0] C2_READ_LINE  = 3'd2,
    parameter logic [CTR_W-1:0] C2_WRITE_LINE = 3'd3,
    parameter logic [CTR_W-1:0] C2_RESPONSE   = 3'd7
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDR_W-1:0]        A1,
    inout  wire  [DATA_W-1:0]        D1,
    inout  wire  [CTR_W-1:0]         C1,
    input  logic                     DUMP,
    output logic                     core_req,
    output logic                     core_we,
    output logic [ADDR_W-1:0]        core_addr,
    output logic [DATA_W*BEATS-1:0]  core_wdata,
    input  logic                     core_ack,
    input  logic [DATA_W*BEATS-1:0]  core_rdata,
    output logic                     core_dump,
    output logic                     busy,
    output logic [2:0]               dbg_state_o
);

    localparam int unsigned      LINE_W    = DATA_W * BEATS;
    localparam int unsigned      CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WR_COLLECT = 3'd1,
        WR_REQ     = 3'd2,
        WR_RESP    = 3'd3,
        RD_TURN    = 3'd4,
        RD_REQ     = 3'd5,
        RD_SEND    = 3'd6
    } state_e;

    state_e              state_q,      state_d;
    logic [CNT_W-1:0]    cnt_q,        cnt_d;
    logic                core_req_q,   core_req_d;
    logic                core_we_q,    core_we_d;
    logic [ADDR_W-1:0]   core_addr_q,  core_addr_d;
    logic [LINE_W-1:0]   core_wdata_q, core_wdata_d;
    logic [LINE_W-1:0]   rbuf_q,       rbuf_d;
    logic                core_dump_q,  core_dump_d;
    logic                busy_q,       busy_d;

    logic                d_oe;
    logic [DATA_W-1:0]   d1_out;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        core_req_d   = core_req_q;
        core_we_d    = core_we_q;
        core_addr_d  = core_addr_q;
        core_wdata_d = core_wdata_q;
        rbuf_d       = rbuf_q;
        core_dump_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A command wins over DUMP in the same cycle; Z/X or unknown
                // codes fall into default and are ignored.
                case (C1)
                    C2_WRITE_LINE: begin
                        core_addr_d = A1;
                        cnt_d       = '0;
                        state_d     = WR_COLLECT;
                    end
                    C2_READ_LINE: begin
                        core_addr_d = A1;
                        state_d     = RD_TURN;
                    end
                    C2_NOP:  core_dump_d = DUMP;
                    default: core_dump_d = DUMP;
                endcase
            end
            WR_COLLECT: begin
                // Beats shift in from the top: after BEATS beats, beat k
                // sits at core_wdata[DATA_W*k +: DATA_W].
                core_wdata_d = {D1, core_wdata_q[LINE_W-1:DATA_W]};
                if (cnt_q == LAST_BEAT) begin
                    cnt_d      = '0;
                    core_req_d = 1'b1;
                    core_we_d  = 1'b1;
                    state_d    = WR_REQ;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WR_REQ: begin
                if (core_ack) begin
                    core_req_d = 1'b0;
                    state_d    = WR_RESP;
                end
            end
            WR_RESP: begin
                state_d = IDLE;
            end
            RD_TURN: begin
                core_req_d = 1'b1;
                core_we_d  = 1'b0;
                state_d    = RD_REQ;
            end
            RD_REQ: begin
                if (core_ack) begin
                    rbuf_d     = core_rdata;
                    core_req_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = RD_SEND;
                end
            end
            RD_SEND: begin
                // Low beat is on D1 now; shift the next one down.
                rbuf_d = rbuf_q >> DATA_W;
                if (cnt_q == LAST_BEAT) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            core_req_q   <= 1'b0;
            core_we_q    <= 1'b0;
            core_addr_q  <= '0;
            core_wdata_q <= '0;
            rbuf_q       <= '0;
            core_dump_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            core_req_q   <= core_req_d;
            core_we_q    <= core_we_d;
            core_addr_q  <= core_addr_d;
            core_wdata_q <= core_wdata_d;
            rbuf_q       <= rbuf_d;
            core_dump_q  <= core_dump_d;
            busy_q       <= busy_d;
        end
    end

    // The slave owns the bus only in the two responding states; D1 carries
    // zero during the one-cycle write acknowledge.
    assign d_oe   = (state_q == WR_RESP) || (state_q == RD_SEND);
    assign d1_out = (state_q == RD_SEND) ? rbuf_q[DATA_W-1:0] : '0;

    assign D1 = d_oe ? d1_out      : 'z;
    assign C1 = d_oe ? C2_RESPONSE : 'z;

    assign core_req    = core_req_q;
    assign core_we     = core_we_q;
    assign core_addr   = core_addr_q;
    assign core_wdata  = core_wdata_q;
    assign core_dump   = core_dump_q;
    assign busy        = busy_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_cache_bus_slave.sv
module tb_cache_bus_slave;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT connections ----------------
  logic [14:0]  A1;
  logic         DUMP;
  logic         core_ack;
  logic [127:0] core_rdata;
  wire  [15:0]  D1;
  wire  [2:0]   C1;
  logic         core_req;
  logic         core_we;
  logic [14:0]  core_addr;
  logic [127:0] core_wdata;
  logic         core_dump;
  logic         busy;
  logic [2:0]   dbg_state;

  logic [15:0]  tb_d1;
  logic         tb_d1_oe;
  logic [2:0]   tb_c1;
  logic         tb_c1_oe;

  assign D1 = tb_d1_oe ? tb_d1 : 'z;
  assign C1 = tb_c1_oe ? tb_c1 : 'z;

  cache_bus_slave dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .A1          (A1),
    .D1          (D1),
    .C1          (C1),
    .DUMP        (DUMP),
    .core_req    (core_req),
    .core_we     (core_we),
    .core_addr   (core_addr),
    .core_wdata  (core_wdata),
    .core_ack    (core_ack),
    .core_rdata  (core_rdata),
    .core_dump   (core_dump),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int dump_cnt = 0;

  logic [15:0]  exp_q[$];       // expected D1 values on C1==7 cycles
  logic [15:0]  exp_req_q[$];   // expected {we, addr} per core request
  logic [127:0] exp_line_q[$];  // expected write lines
  logic         prev_req = 1'b0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (core_req && !prev_req) begin
        check("req_queue_nonempty", 128'(exp_req_q.size() != 0), 128'd1);
        if (exp_req_q.size() != 0) begin
          logic [15:0] e;
          e = exp_req_q.pop_front();
          check("req_we", 128'(core_we), 128'(e[15]));
          check("req_addr", 128'(core_addr), 128'(e[14:0]));
          if (e[15]) begin
            check("wline_queue_nonempty", 128'(exp_line_q.size() != 0), 128'd1);
            if (exp_line_q.size() != 0) check("req_wdata", core_wdata, exp_line_q.pop_front());
          end
        end
      end
      if (C1 == 3'd7) begin
        check("resp_queue_nonempty", 128'(exp_q.size() != 0), 128'd1);
        if (exp_q.size() != 0) check("resp_d1", 128'(D1), 128'(exp_q.pop_front()));
      end
      if (core_dump) dump_cnt <= dump_cnt + 1;
    end
    prev_req <= core_req;
  end

  // ---------------- driver tasks ----------------
  task automatic do_write(input logic [14:0] addr, input logic [127:0] line,
                          input int ack_delay, input logic dump_mid);
    exp_req_q.push_back({1'b1, addr});
    exp_line_q.push_back(line);
    tb_c1 = 3'd3; tb_c1_oe = 1'b1; A1 = addr; DUMP = dump_mid;
    step();
    check("wr_busy", 128'(busy), 128'd1);
    tb_c1_oe = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tb_d1 = line[16*k +: 16]; tb_d1_oe = 1'b1;
      step();
    end
    tb_d1_oe = 1'b0; DUMP = 1'b0;
    check("wr_req_latency", 128'(core_req), 128'd1);
    check("wr_we", 128'(core_we), 128'd1);
    for (int i = 0; i < ack_delay; i++) begin
      step();
      check("wr_hold_req", 128'(core_req), 128'd1);
      check("wr_hold_data", core_wdata, line);
    end
    core_ack = 1'b1;
    exp_q.push_back(16'h0000);
    step();
    core_ack = 1'b0;
    check("wr_req_drop", 128'(core_req), 128'd0);
    step();
    check("wr_idle_busy", 128'(busy), 128'd0);
  endtask

  task automatic do_read(input logic [14:0] addr, input logic [127:0] rdata, input int ack_delay);
    exp_req_q.push_back({1'b0, addr});
    tb_c1 = 3'd2; tb_c1_oe = 1'b1; A1 = addr;
    step();
    tb_c1_oe = 1'b0;
    check("rd_busy", 128'(busy), 128'd1);
    check("rd_turn_noreq", 128'(core_req), 128'd0);
    step();
    check("rd_req", 128'(core_req), 128'd1);
    check("rd_we", 128'(core_we), 128'd0);
    repeat (ack_delay) step();
    core_rdata = rdata; core_ack = 1'b1;
    for (int k = 0; k < 8; k++) exp_q.push_back(rdata[16*k +: 16]);
    step();
    core_ack = 1'b0;
    core_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
    check("rd_req_drop", 128'(core_req), 128'd0);
    repeat (8) step();
    check("rd_idle_busy", 128'(busy), 128'd0);
    check("rd_idle_state", 128'(dbg_state), 128'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int d0;
    rst_n = 1'b0; A1 = '0; DUMP = 1'b0; core_ack = 1'b0; core_rdata = '0;
    tb_d1 = '0; tb_d1_oe = 1'b0; tb_c1 = '0; tb_c1_oe = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", 128'(core_req), 128'd0);
    check("rst_we", 128'(core_we), 128'd0);
    check("rst_addr", 128'(core_addr), 128'd0);
    check("rst_wdata", core_wdata, 128'd0);
    check("rst_dump", 128'(core_dump), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_state", 128'(dbg_state), 128'd0);
    check("rst_c1_released", 128'(C1 != 3'd7), 128'd1);
    rst_n = 1'b1;
    step();

    // Reset in the middle of a write burst.
    tb_c1 = 3'd3; tb_c1_oe = 1'b1; A1 = 15'h0010;
    step();
    tb_c1_oe = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tb_d1 = 16'hA5A0 + 16'(k); tb_d1_oe = 1'b1;
      step();
    end
    tb_d1_oe = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 128'(busy), 128'd0);
    check("midrst_req", 128'(core_req), 128'd0);
    check("midrst_wdata", core_wdata, 128'd0);
    check("midrst_addr", 128'(core_addr), 128'd0);
    check("midrst_state", 128'(dbg_state), 128'd0);
    check("midrst_c1_released", 128'(C1 != 3'd7), 128'd1);
    step();
    rst_n = 1'b1;
    step();

    // Directed write line after the aborted burst.
    do_write(15'h0000, 128'h0E0F0C0D0A0B08090607040502030001, 2, 1'b0);

    // Directed read line, core acks 3 cycles later.
    do_read(15'h1234, 128'h0F0E0D0C0B0A09080706050403020100, 3);

    // DUMP for two cycles in IDLE.
    d0 = dump_cnt;
    DUMP = 1'b1;
    step(); step();
    DUMP = 1'b0;
    step(); step(); step();
    check("dump_idle_count", 128'(dump_cnt - d0), 128'd2);

    // DUMP held through a command cycle and the whole beat collection.
    d0 = dump_cnt;
    do_write(15'h2A2A, {$urandom(), $urandom(), $urandom(), $urandom()}, 0, 1'b1);
    step();
    check("dump_busy_count", 128'(dump_cnt - d0), 128'd0);

    // Back-to-back writes, the second with a 20-cycle ack stall.
    do_write(15'h0101, {$urandom(), $urandom(), $urandom(), $urandom()}, 1, 1'b0);
    do_write(15'h7FFF, {$urandom(), $urandom(), $urandom(), $urandom()}, 20, 1'b0);

    // Invalid command code in IDLE.
    tb_c1 = 3'd5; tb_c1_oe = 1'b1; A1 = 15'h0055;
    step();
    tb_c1_oe = 1'b0;
    check("inv_busy", 128'(busy), 128'd0);
    check("inv_state", 128'(dbg_state), 128'd0);
    step();
    check("inv_busy2", 128'(busy), 128'd0);
    check("inv_req", 128'(core_req), 128'd0);

    // Random mix of reads and writes.
    for (int i = 0; i < 6; i++) begin
      logic [14:0]  ra;
      logic [127:0] rl;
      ra = 15'($urandom_range(0, 32767));
      rl = {$urandom(), $urandom(), $urandom(), $urandom()};
      if ($urandom_range(0, 1) == 1) do_write(ra, rl, $urandom_range(0, 4), 1'b0);
      else                           do_read(ra, rl, $urandom_range(0, 4));
      repeat ($urandom_range(0, 2)) step();
    end

    repeat (4) step();
    check("end_exp_q_empty", 128'(exp_q.size()), 128'd0);
    check("end_req_q_empty", 128'(exp_req_q.size()), 128'd0);
    check("end_line_q_empty", 128'(exp_line_q.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
